// File: rtl/axil_csr_master.sv
// AXI4-Lite master that turns single CSR commands into AW/W/B or AR/R transactions.
// Optional write read-back and compare is enabled with the AXIL_RDBACK_EN macro.
`ifndef CSR_ADDR_WIDTH
`define CSR_ADDR_WIDTH 12
`endif
`ifndef DATA_WIDTH
`define DATA_WIDTH 32
`endif

module axil_csr_master #(
  parameter int ADDR_WIDTH = `CSR_ADDR_WIDTH,
  parameter int DATA_WIDTH = `DATA_WIDTH
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    cmd_valid,
  output logic                    cmd_ready,
  input  logic                    cmd_write,
  input  logic [ADDR_WIDTH-1:0]   cmd_addr,
  input  logic [DATA_WIDTH-1:0]   cmd_wdata,
  output logic                    rsp_valid,
  input  logic                    rsp_ready,
  output logic [DATA_WIDTH-1:0]   rsp_rdata,
  output logic [1:0]              rsp_resp,
  output logic                    rsp_mismatch,
  output logic [ADDR_WIDTH-1:0]   m_axi_awaddr,
  output logic [2:0]              m_axi_awprot,
  output logic                    m_axi_awvalid,
  input  logic                    m_axi_awready,
  output logic [DATA_WIDTH-1:0]   m_axi_wdata,
  output logic [DATA_WIDTH/8-1:0] m_axi_wstrb,
  output logic                    m_axi_wvalid,
  input  logic                    m_axi_wready,
  input  logic [1:0]              m_axi_bresp,
  input  logic                    m_axi_bvalid,
  output logic                    m_axi_bready,
  output logic [ADDR_WIDTH-1:0]   m_axi_araddr,
  output logic [2:0]              m_axi_arprot,
  output logic                    m_axi_arvalid,
  input  logic                    m_axi_arready,
  input  logic [DATA_WIDTH-1:0]   m_axi_rdata,
  input  logic [1:0]              m_axi_rresp,
  input  logic                    m_axi_rvalid,
  output logic                    m_axi_rready
);

`ifdef AXIL_RDBACK_EN
  typedef enum logic [2:0] {IDLE, WR, WR_RESP, RD, RD_DATA, RB, RB_DATA, RSP} state_t;
  localparam logic [1:0] RESP_OKAY = 2'b00;
`else
  typedef enum logic [2:0] {IDLE, WR, WR_RESP, RD, RD_DATA, RSP} state_t;
`endif

  typedef struct packed {
    logic                  write;
    logic [ADDR_WIDTH-1:0] addr;
    logic [DATA_WIDTH-1:0] wdata;
  } cmd_t;

  state_t state, state_nxt;
  cmd_t   cmd_q;
  logic   aw_done, w_done;
  logic   aw_hs, w_hs;

  assign aw_hs = m_axi_awvalid && m_axi_awready;
  assign w_hs  = m_axi_wvalid  && m_axi_wready;

  assign m_axi_awaddr = cmd_q.addr;
  assign m_axi_araddr = cmd_q.addr;
  assign m_axi_wdata  = cmd_q.wdata;
  assign m_axi_wstrb  = '1;
  assign m_axi_awprot = 3'b000;
  assign m_axi_arprot = 3'b000;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (cmd_valid && cmd_ready) state_nxt = cmd_write ? WR : RD;
      // AW and W finish independently; leave once both are done
      WR:      if ((aw_done || aw_hs) && (w_done || w_hs)) state_nxt = WR_RESP;
`ifdef AXIL_RDBACK_EN
      WR_RESP: if (m_axi_bvalid) state_nxt = RB;
      RB:      if (m_axi_arready) state_nxt = RB_DATA;
      RB_DATA: if (m_axi_rvalid) state_nxt = RSP;
`else
      WR_RESP: if (m_axi_bvalid) state_nxt = RSP;
`endif
      RD:      if (m_axi_arready) state_nxt = RD_DATA;
      RD_DATA: if (m_axi_rvalid) state_nxt = RSP;
      RSP:     if (rsp_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Valids come from state and done flags only, never from a ready
  always_comb begin
    cmd_ready     = 1'b0;
    m_axi_awvalid = 1'b0;
    m_axi_wvalid  = 1'b0;
    m_axi_bready  = 1'b0;
    m_axi_arvalid = 1'b0;
    m_axi_rready  = 1'b0;
    rsp_valid     = 1'b0;
    case (state)
      IDLE:    cmd_ready = ~rst;
      WR: begin
        m_axi_awvalid = ~aw_done;
        m_axi_wvalid  = ~w_done;
      end
      WR_RESP: m_axi_bready  = 1'b1;
      RD:      m_axi_arvalid = 1'b1;
      RD_DATA: m_axi_rready  = 1'b1;
`ifdef AXIL_RDBACK_EN
      RB:      m_axi_arvalid = 1'b1;
      RB_DATA: m_axi_rready  = 1'b1;
`endif
      RSP:     rsp_valid = 1'b1;
      default: ;
    endcase
  end

`ifdef AXIL_RDBACK_EN
  logic [1:0] bresp_q;
  logic       mism_q;
  assign rsp_mismatch = mism_q;
`else
  logic unused_cmd_write;
  assign unused_cmd_write = cmd_q.write;
  assign rsp_mismatch     = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cmd_q     <= '0;
      aw_done   <= 1'b0;
      w_done    <= 1'b0;
      rsp_rdata <= '0;
      rsp_resp  <= 2'b00;
`ifdef AXIL_RDBACK_EN
      bresp_q   <= 2'b00;
      mism_q    <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: if (cmd_valid && cmd_ready) begin
          cmd_q   <= '{write: cmd_write, addr: cmd_addr, wdata: cmd_wdata};
          aw_done <= 1'b0;
          w_done  <= 1'b0;
        end
        WR: begin
          if (aw_hs) aw_done <= 1'b1;
          if (w_hs)  w_done  <= 1'b1;
        end
        WR_RESP: if (m_axi_bvalid) begin
`ifdef AXIL_RDBACK_EN
          bresp_q   <= m_axi_bresp;
`else
          rsp_resp  <= m_axi_bresp;
          rsp_rdata <= '0;
`endif
        end
        RD_DATA: if (m_axi_rvalid) begin
          rsp_rdata <= m_axi_rdata;
          rsp_resp  <= m_axi_rresp;
`ifdef AXIL_RDBACK_EN
          mism_q    <= 1'b0;
`endif
        end
`ifdef AXIL_RDBACK_EN
        // A failed write reports its own code ahead of the read-back code
        RB_DATA: if (m_axi_rvalid) begin
          rsp_rdata <= m_axi_rdata;
          rsp_resp  <= (bresp_q != RESP_OKAY) ? bresp_q : m_axi_rresp;
          mism_q    <= cmd_q.write && (m_axi_rdata != cmd_q.wdata);
        end
`endif
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_axil_csr_master.sv
module tb_axil_csr_master;
`ifdef AXIL_RDBACK_EN
  localparam bit RDBK = 1'b1;
`else
  localparam bit RDBK = 1'b0;
`endif
  localparam int WLAT = RDBK ? 5 : 3;
  localparam logic [11:0] RO_ADDR = 12'h020;

  typedef struct packed {
    logic [31:0] rdata;
    logic [1:0]  resp;
    logic        mism;
  } exp_t;

  logic clk = 1'b0, rst = 1'b1;
  logic cmd_valid = 0, cmd_ready, cmd_write = 0;
  logic [11:0] cmd_addr = 0;
  logic [31:0] cmd_wdata = 0;
  logic rsp_valid, rsp_ready = 0, rsp_mismatch;
  logic [31:0] rsp_rdata;
  logic [1:0] rsp_resp;
  logic [11:0] awaddr, araddr;
  logic [2:0] awprot, arprot;
  logic awvalid, awready, wvalid, wready, bvalid, bready, arvalid, arready, rvalid, rready;
  logic [31:0] wdata, rdata;
  logic [3:0] wstrb;
  logic [1:0] bresp, rresp;

  int n_cmp = 0, n_err = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  axil_csr_master #(.ADDR_WIDTH(12), .DATA_WIDTH(32)) dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
    .rsp_resp(rsp_resp), .rsp_mismatch(rsp_mismatch),
    .m_axi_awaddr(awaddr), .m_axi_awprot(awprot), .m_axi_awvalid(awvalid), .m_axi_awready(awready),
    .m_axi_wdata(wdata), .m_axi_wstrb(wstrb), .m_axi_wvalid(wvalid), .m_axi_wready(wready),
    .m_axi_bresp(bresp), .m_axi_bvalid(bvalid), .m_axi_bready(bready),
    .m_axi_araddr(araddr), .m_axi_arprot(arprot), .m_axi_arvalid(arvalid), .m_axi_arready(arready),
    .m_axi_rdata(rdata), .m_axi_rresp(rresp), .m_axi_rvalid(rvalid), .m_axi_rready(rready)
  );

  always #5 clk = ~clk;

  int aw_dly = 0, w_dly = 0;
  logic [1:0] bresp_k = 2'b00, rresp_k = 2'b00;
  int aw_wait, w_wait;
  logic got_aw, got_w;
  logic [11:0] s_addr, wa;
  logic [31:0] s_data, wd;
  logic [31:0] mem [16];

  assign awready = awvalid && (aw_wait >= aw_dly);
  assign wready  = wvalid && (w_wait >= w_dly);
  assign arready = arvalid;
  assign wa = (awvalid && awready) ? awaddr : s_addr;
  assign wd = (wvalid && wready) ? wdata : s_data;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      aw_wait <= 0; w_wait <= 0; got_aw <= 0; got_w <= 0;
      s_addr <= 0; s_data <= 0; bvalid <= 0; bresp <= 0;
      rvalid <= 0; rdata <= 0; rresp <= 0;
      for (int i = 0; i < 16; i++) mem[i] <= 32'h0;
      mem[4] <= 32'hDEAD_BEEF;
    end else begin
      if (awvalid && !awready) aw_wait <= aw_wait + 1; else aw_wait <= 0;
      if (wvalid && !wready) w_wait <= w_wait + 1; else w_wait <= 0;
      if (awvalid && awready) begin got_aw <= 1; s_addr <= awaddr; end
      if (wvalid && wready) begin got_w <= 1; s_data <= wdata; end
      if ((got_aw || (awvalid && awready)) && (got_w || (wvalid && wready)) && !bvalid) begin
        bvalid <= 1; bresp <= bresp_k; got_aw <= 0; got_w <= 0;
        if (wa != RO_ADDR) mem[wa[5:2]] <= wd;
      end
      if (bvalid && bready) bvalid <= 0;
      if (arvalid && arready) begin
        rvalid <= 1; rresp <= rresp_k;
        rdata <= (araddr == RO_ADDR) ? 32'h0 : mem[araddr[5:2]];
      end
      if (rvalid && rready) rvalid <= 0;
    end
  end

  int cyc = 0, awv_n = 0, wv_n = 0, aw_hs_n = 0, w_hs_n = 0, ar_hs_n = 0, rsp_hs_n = 0;
  logic [11:0] last_awaddr = 0, last_araddr = 0, aw_pa = 0;
  logic [31:0] last_wdata = 0, w_pd = 0;
  logic [3:0] last_wstrb = 0;
  logic aw_pend = 0, w_pend = 0, proto_bad = 0;

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (awvalid) awv_n <= awv_n + 1;
    if (wvalid) wv_n <= wv_n + 1;
    if (awvalid && awready) begin aw_hs_n <= aw_hs_n + 1; last_awaddr <= awaddr; end
    if (wvalid && wready) begin w_hs_n <= w_hs_n + 1; last_wdata <= wdata; last_wstrb <= wstrb; end
    if (arvalid && arready) begin ar_hs_n <= ar_hs_n + 1; last_araddr <= araddr; end
    if (rsp_valid && rsp_ready) rsp_hs_n <= rsp_hs_n + 1;
    if (rst) begin
      aw_pend <= 0; w_pend <= 0;
    end else begin
      if (aw_pend && (!awvalid || awaddr != aw_pa)) proto_bad <= 1;
      if (w_pend && (!wvalid || wdata != w_pd)) proto_bad <= 1;
      if (awprot != 3'b000 || arprot != 3'b000) proto_bad <= 1;
      aw_pend <= awvalid && !awready; aw_pa <= awaddr;
      w_pend <= wvalid && !wready; w_pd <= wdata;
    end
  end

  always @(posedge clk) begin
    if (!rst && rsp_valid) begin
      n_cmp++;
      if (cmd_ready !== 1'b0) begin
        n_err++;
        $error("FAIL rsp_cmd_ready_excl observed=0x%0h expected=0x0", cmd_ready);
      end
    end
  end

  exp_t sb[$];
  int acc_cyc = 0;

  function automatic exp_t wexp(input logic [11:0] a, input logic [31:0] d, input logic [1:0] br);
    exp_t e;
    logic [31:0] rb;
    rb = (a == RO_ADDR) ? 32'h0 : d;
    if (RDBK) e = '{rdata: rb, resp: (br != 2'b00) ? br : 2'b00, mism: (rb != d)};
    else      e = '{rdata: 32'h0, resp: br, mism: 1'b0};
    return e;
  endfunction

  task automatic send(input string tag, input bit wr, input logic [11:0] a, input logic [31:0] d, input exp_t e);
    int t = 0;
    cmd_valid = 1; cmd_write = wr; cmd_addr = a; cmd_wdata = d;
    while (!cmd_ready && t < 50) begin @(negedge clk); t++; end
    chk({tag, "_accept"}, cmd_ready, 1'b1);
    if (cmd_ready) begin
      acc_cyc = cyc;
      sb.push_back(e);
    end
    @(negedge clk);
    cmd_valid = 0;
  endtask

  task automatic get_rsp(input string tag, input int lat, input int hold);
    int t = 0;
    exp_t e;
    bit stable = 1;
    logic [34:0] snap;
    while (!rsp_valid && t < 100) begin @(negedge clk); t++; end
    chk({tag, "_rsp_valid"}, rsp_valid, 1'b1);
    chk({tag, "_sb_nonempty"}, sb.size() > 0, 1'b1);
    if (rsp_valid && sb.size() > 0) begin
      e = sb.pop_front();
      if (lat >= 0) chk({tag, "_latency"}, cyc - acc_cyc, lat);
      chk({tag, "_rdata"}, rsp_rdata, e.rdata);
      chk({tag, "_resp"}, rsp_resp, e.resp);
      chk({tag, "_mismatch"}, rsp_mismatch, e.mism);
      snap = {rsp_mismatch, rsp_resp, rsp_rdata};
      repeat (hold) begin
        @(negedge clk);
        if (!rsp_valid || cmd_ready || {rsp_mismatch, rsp_resp, rsp_rdata} !== snap) stable = 0;
      end
      if (hold > 0) chk({tag, "_hold_stable"}, stable, 1'b1);
      rsp_ready = 1;
      @(negedge clk);
      rsp_ready = 0;
      chk({tag, "_back_idle"}, {cmd_ready, rsp_valid}, 2'b10);
    end
  endtask

  int awv0, wv0, aw0, w0, ar0, rs0;
  task automatic snap_cnt();
    awv0 = awv_n; wv0 = wv_n; aw0 = aw_hs_n; w0 = w_hs_n; ar0 = ar_hs_n; rs0 = rsp_hs_n;
  endtask

  initial begin
    repeat (3) @(negedge clk);
    chk("reset_outputs", {cmd_ready, awvalid, wvalid, bready, arvalid, rready, rsp_valid,
                          rsp_mismatch, rsp_resp, rsp_rdata, awaddr}, 0);
    rst = 0;
    #1;
    chk("cmd_ready_after_release", cmd_ready, 1'b1);
    @(negedge clk);

    snap_cnt();
    send("wr08", 1, 12'h008, 32'h0000_0003, wexp(12'h008, 32'h3, 2'b00));
    get_rsp("wr08", WLAT, 0);
    chk("wr08_aw_count", aw_hs_n - aw0, 1);
    chk("wr08_w_count", w_hs_n - w0, 1);
    chk("wr08_awaddr", last_awaddr, 12'h008);
    chk("wr08_wdata", last_wdata, 32'h3);
    chk("wr08_wstrb", last_wstrb, 4'hF);

    aw_dly = 4;
    snap_cnt();
    send("wr_awdly", 1, 12'h004, 32'h1111_2222, wexp(12'h004, 32'h1111_2222, 2'b00));
    get_rsp("wr_awdly", -1, 0);
    chk("wr_awdly_awvalid_cycles", awv_n - awv0, 5);
    chk("wr_awdly_wvalid_cycles", wv_n - wv0, 1);
    chk("wr_awdly_aw_count", aw_hs_n - aw0, 1);
    chk("wr_awdly_rsp_count", rsp_hs_n - rs0, 1);
    aw_dly = 0;

    w_dly = 3; bresp_k = 2'b10;
    snap_cnt();
    send("wr_wdly", 1, 12'h00C, 32'h1234_5678, wexp(12'h00C, 32'h1234_5678, 2'b10));
    get_rsp("wr_wdly", -1, 0);
    chk("wr_wdly_wvalid_cycles", wv_n - wv0, 4);
    chk("wr_wdly_awvalid_cycles", awv_n - awv0, 1);
    w_dly = 0; bresp_k = 2'b00;

    rresp_k = 2'b10;
    snap_cnt();
    send("rd10", 0, 12'h010, 32'h0, '{rdata: 32'hDEAD_BEEF, resp: 2'b10, mism: 1'b0});
    get_rsp("rd10", 3, 0);
    chk("rd10_araddr", last_araddr, 12'h010);
    chk("rd10_ar_count", ar_hs_n - ar0, 1);
    rresp_k = 2'b00;

    send("rd08", 0, 12'h008, 32'h0, '{rdata: 32'h3, resp: 2'b00, mism: 1'b0});
    get_rsp("rd08", 3, 0);

    send("wr_hold", 1, 12'h014, 32'hCAFE_0001, wexp(12'h014, 32'hCAFE_0001, 2'b00));
    get_rsp("wr_hold", WLAT, 10);

    bresp_k = 2'b11;
    send("wr_decerr", 1, 12'h018, 32'h0000_00A5, wexp(12'h018, 32'hA5, 2'b11));
    get_rsp("wr_decerr", WLAT, 0);
    bresp_k = 2'b00;

    aw_dly = 4;
    snap_cnt();
    send("wr_rst", 1, 12'h01C, 32'h7777_7777, wexp(12'h01C, 32'h7777_7777, 2'b00));
    chk("wr_rst_awvalid_before", awvalid, 1'b1);
    rst = 1;
    #1;
    chk("mid_reset_outputs", {cmd_ready, awvalid, wvalid, bready, arvalid, rready, rsp_valid,
                              rsp_mismatch, rsp_resp, rsp_rdata, awaddr}, 0);
    repeat (2) @(negedge clk);
    chk("mid_reset_no_rsp", {rsp_valid, 32'(rsp_hs_n - rs0)}, 0);
    sb.delete();
    aw_dly = 0;
    rst = 0;
    #1;
    chk("cmd_ready_after_mid_reset", cmd_ready, 1'b1);
    @(negedge clk);
    send("wr_post_rst", 1, 12'h01C, 32'h0BAD_F00D, wexp(12'h01C, 32'h0BAD_F00D, 2'b00));
    get_rsp("wr_post_rst", WLAT, 0);
    send("rd_post_rst", 0, 12'h01C, 32'h0, '{rdata: 32'h0BAD_F00D, resp: 2'b00, mism: 1'b0});
    get_rsp("rd_post_rst", 3, 0);

`ifdef AXIL_RDBACK_EN
    snap_cnt();
    send("rb_ro", 1, RO_ADDR, 32'h0000_005A, wexp(RO_ADDR, 32'h5A, 2'b00));
    get_rsp("rb_ro", WLAT, 0);
    chk("rb_ro_ar_count", ar_hs_n - ar0, 1);
    chk("rb_ro_araddr", last_araddr, RO_ADDR);
    send("rb_rw", 1, 12'h00C, 32'h0000_005A, wexp(12'h00C, 32'h5A, 2'b00));
    get_rsp("rb_rw", WLAT, 0);
`endif

    chk("protocol_stable", proto_bad, 1'b0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
